// File: rtl/mna_resp_flit_depacketizer.sv
// NoC response flit depacketizer: header + payload flits in, AXI-Lite-style read
// beats (through a small FIFO) or a single write response out.
module mna_resp_flit_depacketizer #(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+4:0] noc_data,
    input  logic              noc_valid,
    output logic              noc_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [1:0]        wr_resp,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, DATA} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    state_t           state_q, state_d;
    logic [1:0]       resp_q, resp_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       wr_resp_q, wr_resp_d;
    logic             wr_valid_q, wr_valid_d;
    logic             proto_err_q, proto_err_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    beat_t            mem_q [FIFO_DEPTH];

    logic [1:0] flit_type;
    logic       is_hdr, is_pay, hdr_rd, wr_slot_free;
    logic       fifo_full, fifo_empty, fire, push, pop, last_beat;
    beat_t      push_beat;

    assign flit_type    = noc_data[DATA_W+4:DATA_W+3];
    assign is_hdr       = (flit_type == 2'b10);
    assign is_pay       = (flit_type == 2'b01);
    assign hdr_rd       = noc_data[0];
    assign wr_slot_free = !wr_valid_q || wr_ready;
    assign fifo_empty   = (wptr_q == rptr_q);
    assign fifo_full    = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign pop          = !fifo_empty && rd_ready;
    // Compare before increment so len = all-ones never needs an extra counter bit.
    assign last_beat    = (cnt_q == len_q);

    always_comb begin
        if (state_q == IDLE) noc_ready = !(is_hdr && !hdr_rd && !wr_slot_free);
        else                 noc_ready = !fifo_full || rd_ready;
    end

    assign fire = noc_valid && noc_ready;

    always_comb begin
        state_d     = state_q;
        resp_d      = resp_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wr_resp_d   = wr_resp_q;
        wr_valid_d  = wr_valid_q && !wr_ready;
        proto_err_d = 1'b0;
        push        = 1'b0;
        push_beat   = '{data: noc_data[DATA_W-1:0], resp: resp_q, last: last_beat};
        if (fire) begin
            case (state_q)
                IDLE: begin
                    if (!is_hdr) begin
                        proto_err_d = 1'b1;
                    end else if (hdr_rd) begin
                        state_d = DATA;
                        resp_d  = noc_data[2:1];
                        len_d   = noc_data[LEN_W+2:3];
                        cnt_d   = '0;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_resp_d  = noc_data[2:1];
                    end
                end
                default: begin
                    if (!is_pay) begin
                        proto_err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (last_beat) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            resp_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wr_resp_q   <= '0;
            wr_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            resp_q      <= resp_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wr_resp_q   <= wr_resp_d;
            wr_valid_q  <= wr_valid_d;
            proto_err_q <= proto_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            if (push) mem_q[wptr_q[AW-1:0]] <= push_beat;
        end
    end

    assign rd_valid  = !fifo_empty;
    assign rd_data   = mem_q[rptr_q[AW-1:0]].data;
    assign rd_resp   = mem_q[rptr_q[AW-1:0]].resp;
    assign rd_last   = mem_q[rptr_q[AW-1:0]].last;
    assign wr_resp   = wr_resp_q;
    assign wr_valid  = wr_valid_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_mna_resp_flit_depacketizer.sv
// Randomized bench for the response flit depacketizer against a transaction-level
// model: expected read beats / write responses / drop counts kept in queues.
module tb_mna_resp_flit_depacketizer;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int FW = DW + 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] noc_data = '0;
    logic          noc_valid = 1'b0;
    logic          noc_ready;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [1:0]    wr_resp;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic          proto_err;

    mna_resp_flit_depacketizer #(.DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .noc_data(noc_data), .noc_valid(noc_valid),
        .noc_ready(noc_ready), .rd_data(rd_data), .rd_resp(rd_resp),
        .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wr_resp(wr_resp), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: what the spec says each accepted flit should produce.
    logic [DW+2:0] exp_rd[$];
    logic [1:0]    exp_wr[$];
    int            exp_perr = 0;
    int            obs_perr = 0;
    bit            m_busy = 0;
    int            m_left = 0;
    logic [1:0]    m_resp = '0;
    bit            rand_rd = 0;

    function automatic logic [FW-1:0] hdr(input bit rd, input logic [1:0] resp, input logic [LW-1:0] len);
        logic [FW-1:0] f;
        f = '0;
        f[FW-1:FW-2] = 2'b10;
        f[0] = rd;
        f[2:1] = resp;
        f[LW+2:3] = len;
        return f;
    endfunction

    function automatic logic [FW-1:0] pay(input logic [DW-1:0] d);
        return {2'b01, 3'b000, d};
    endfunction

    function automatic logic [FW-1:0] bad(input logic [1:0] t, input logic [DW+2:0] rest);
        return {t, rest};
    endfunction

    task automatic model_accept(input logic [FW-1:0] f);
        logic [1:0] t;
        t = f[FW-1:FW-2];
        if (!m_busy) begin
            if (t == 2'b10) begin
                if (f[0]) begin
                    m_busy = 1;
                    m_left = int'(f[LW+2:3]) + 1;
                    m_resp = f[2:1];
                end else begin
                    exp_wr.push_back(f[2:1]);
                end
            end else begin
                exp_perr++;
            end
        end else if (t == 2'b01) begin
            exp_rd.push_back({f[DW-1:0], m_resp, m_left == 1});
            m_left--;
            if (m_left == 0) m_busy = 0;
        end else begin
            exp_perr++;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [FW-1:0] f);
        int k;
        k = 0;
        noc_data  = f;
        noc_valid = 1'b1;
        @(negedge clk);
        while (!noc_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("send_timeout", 1, 0);
        model_accept(f);
        @(posedge clk);
        #1 noc_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        rd_ready = 1'b1;
        while ((exp_rd.size() != 0 || exp_wr.size() != 0) && k < 500) begin
            tick();
            k++;
        end
        tick();
        check("drain_rd_left", exp_rd.size(), 0);
        check("drain_wr_left", exp_wr.size(), 0);
    endtask

    always @(posedge clk) if (rand_rd) #1 rd_ready = 1'($urandom_range(0, 1));

    always @(negedge clk) begin
        if (!rst) begin
            if (proto_err) obs_perr++;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", exp_rd.size(), 1);
                else check("rd_beat", {rd_data, rd_resp, rd_last}, exp_rd.pop_front());
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
                else check("wr_resp", wr_resp, exp_wr.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_perr", proto_err, 0);
        check("rst_rd_fields", {rd_data, rd_resp, rd_last}, 0);
        check("rst_wr_resp", wr_resp, 0);
        check("rst_noc_ready", noc_ready, 1);

        // Write response and blocked second write header
        tick();
        wr_ready = 1'b0;
        send(hdr(0, 2'b10, 0));
        @(negedge clk);
        check("wr_valid_lat", wr_valid, 1);
        check("wr_resp_val", wr_resp, 2'b10);
        tick();
        noc_data = hdr(0, 2'b01, 0);
        noc_valid = 1'b1;
        @(negedge clk);
        check("wr_block_ready", noc_ready, 0);
        tick();
        wr_ready = 1'b1;
        send(hdr(0, 2'b01, 0));
        drain();

        // Single read beat
        rd_ready = 1'b0;
        send(hdr(1, 2'b00, 0));
        send(pay(32'hDEADBEEF));
        @(negedge clk);
        check("single_valid", rd_valid, 1);
        check("single_data", rd_data, 32'hDEADBEEF);
        check("single_last", rd_last, 1);
        drain();

        // Burst of 6 with backpressure
        rd_ready = 1'b0;
        send(hdr(1, 2'b11, 5));
        for (int i = 0; i < 4; i++) send(pay(32'h100 + i));
        noc_data = pay(32'h104);
        noc_valid = 1'b1;
        @(negedge clk);
        check("bp_noc_ready", noc_ready, 0);
        tick();
        rd_ready = 1'b1;
        send(pay(32'h104));
        send(pay(32'h105));
        drain();

        // Dropped flits
        send(pay(32'h55));
        @(negedge clk);
        check("perr_pay_idle", proto_err, 1);
        check("perr_no_rd", rd_valid, 0);
        tick();
        send(bad(2'b11, 35'h123));
        @(negedge clk);
        check("perr_type11", proto_err, 1);
        check("perr_no_wr", wr_valid, 0);
        @(negedge clk);
        check("perr_one_pulse", proto_err, 0);
        tick();

        // Reset mid-burst
        rd_ready = 1'b0;
        send(hdr(1, 2'b01, 3));
        send(pay(32'hA0));
        send(pay(32'hA1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rd.delete();
        m_busy = 0;
        m_left = 0;
        @(negedge clk);
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_noc_ready", noc_ready, 1);
        tick();
        send(hdr(0, 2'b01, 0));
        @(negedge clk);
        check("post_rst_wr_valid", wr_valid, 1);
        check("post_rst_wr_resp", wr_resp, 2'b01);
        tick();
        drain();

        // Maximum length burst
        send(hdr(1, 2'b10, 8'hFF));
        for (int i = 0; i < 256; i++) send(pay($urandom));
        drain();

        // Wrap stress with random consumer, writes and drops mixed in
        rand_rd = 1;
        for (int b = 0; b < 40; b++) begin
            int len;
            if ($urandom_range(0, 3) == 0) send(hdr(0, 2'($urandom), 0));
            if ($urandom_range(0, 4) == 0) send(bad(2'($urandom_range(0, 1) * 3), 35'($urandom)));
            len = $urandom_range(0, 7);
            send(hdr(1, 2'($urandom), 8'(len)));
            for (int i = 0; i <= len; i++) begin
                if ($urandom_range(0, 9) == 0) send(hdr(1, 2'b00, 8'h3));
                send(pay($urandom));
            end
        end
        rand_rd = 0;
        tick();
        drain();
        check("perr_count", obs_perr, exp_perr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
